// File: rtl/dcache_port_arbiter_pkg.sv
// Shared helpers for the DCache port arbiter: tag packing and counter sizing.
// Imported by the interface, the round-robin sub-module and the top.
package dcarb_pkg;

  localparam int TAG_MAX_W = 16;

  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Width of an outstanding counter that must hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic logic [TAG_MAX_W-1:0] pack_tag(input int idx,
                                                    input logic [TAG_MAX_W-1:0] id,
                                                    input int id_w);
    return (TAG_MAX_W'(idx) << id_w) | id;
  endfunction

  function automatic int unpack_idx(input logic [TAG_MAX_W-1:0] tag, input int id_w);
    return int'(tag >> id_w);
  endfunction

  function automatic logic [TAG_MAX_W-1:0] unpack_id(input logic [TAG_MAX_W-1:0] tag,
                                                     input int id_w);
    return tag & ((TAG_MAX_W'(1) << id_w) - TAG_MAX_W'(1));
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Bundle of requester-side and cache-side signals around the arbiter.
// DCARB_STATS_EN adds the grant and stall statistics outputs.
interface dcache_port_arbiter_if
  import dcarb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
);
  localparam int TAG_W = idx_w(N_REQ) + ID_W;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ*DATA_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ*ID_W-1:0]   req_id;
  logic [N_REQ-1:0]        req_stall;

  logic                    mem_r;
  logic                    mem_w;
  logic [TAG_W-1:0]        mem_id;
  logic [DATA_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_stall;
  logic                    mem_ready;
  logic [TAG_W-1:0]        mem_id_in;
  logic [DATA_W-1:0]       mem_rdata;

  logic [N_REQ-1:0]        rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic                    tag_err;

`ifdef DCARB_STATS_EN
  logic [N_REQ*16-1:0]     grant_cnt;
  logic [15:0]             stall_cyc;

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_id,
    input  mem_stall, mem_ready, mem_id_in, mem_rdata,
    output req_stall, mem_r, mem_w, mem_id, mem_addr, mem_wdata,
    output rsp_valid, rsp_id, rsp_data, tag_err, grant_cnt, stall_cyc
  );

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_id,
    output mem_stall, mem_ready, mem_id_in, mem_rdata,
    input  req_stall, mem_r, mem_w, mem_id, mem_addr, mem_wdata,
    input  rsp_valid, rsp_id, rsp_data, tag_err, grant_cnt, stall_cyc
  );
`else
  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_id,
    input  mem_stall, mem_ready, mem_id_in, mem_rdata,
    output req_stall, mem_r, mem_w, mem_id, mem_addr, mem_wdata,
    output rsp_valid, rsp_id, rsp_data, tag_err
  );

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_id,
    output mem_stall, mem_ready, mem_id_in, mem_rdata,
    input  req_stall, mem_r, mem_w, mem_id, mem_addr, mem_wdata,
    input  rsp_valid, rsp_id, rsp_data, tag_err
  );
`endif

endinterface

// File: rtl/dcache_port_arbiter_rr.sv
// Combinational N-way round-robin picker: first eligible requester at or
// after the pointer, wrapping; one-hot result, all zero when disabled.
module rr_arbiter
  import dcarb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]          i_elig,
  input  logic                      i_en,
  input  logic [idx_w(N_REQ)-1:0]   i_ptr,
  output logic [N_REQ-1:0]          o_grant
);
  localparam int IDX_W = idx_w(N_REQ);

  logic             w_found;
  logic [IDX_W-1:0] w_slot;

  // N_REQ is a power of two, so the slot index wraps naturally.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_slot  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_slot = i_ptr + IDX_W'(k);
      if (i_en && !w_found && i_elig[w_slot]) begin
        o_grant[w_slot] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one DCache request/response port among N_REQ load/store queues.
// Optional statistics outputs are built when DCARB_STATS_EN is defined.
module dcache_port_arbiter
  import dcarb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4,
  parameter int DATA_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  dcache_port_arbiter_if.slave bus
);
  localparam int IDX_W = idx_w(N_REQ);
  localparam int TAG_W = IDX_W + ID_W;
  localparam int CNT_W = cnt_w(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic              w_anyGrant;
  logic [IDX_W-1:0]  w_grantIdx;
  logic [IDX_W-1:0]  r_rrPtr;
  logic [CNT_W-1:0]  r_outCnt [N_REQ];

  logic              w_selRw;
  logic [DATA_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selData;
  logic [ID_W-1:0]   w_selId;

  int                w_rspIdx;
  logic [IDX_W-1:0]  w_rspSlot;
  logic [ID_W-1:0]   w_rspLocalId;
  logic              w_rspOk;
  logic [N_REQ-1:0]  w_rspOneHot;
  logic [N_REQ-1:0]  w_dec;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = bus.req_valid[i] && (r_outCnt[i] < CNT_MAX);
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_elig  (w_elig),
    .i_en    (~bus.mem_stall),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_grantIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_grantIdx = IDX_W'(i);
    end
  end

  assign w_anyGrant = |w_grant;
  assign w_selRw    = bus.req_rw[w_grantIdx];
  assign w_selAddr  = bus.req_addr[w_grantIdx*DATA_W +: DATA_W];
  assign w_selData  = bus.req_data[w_grantIdx*DATA_W +: DATA_W];
  assign w_selId    = bus.req_id[w_grantIdx*ID_W +: ID_W];

  // Everyone is held off while reset is asserted.
  assign bus.req_stall = rst ? (bus.req_valid & ~w_grant) : '1;

  assign w_rspIdx     = unpack_idx(TAG_MAX_W'(bus.mem_id_in), ID_W);
  assign w_rspSlot    = w_rspIdx[IDX_W-1:0];
  assign w_rspLocalId = ID_W'(unpack_id(TAG_MAX_W'(bus.mem_id_in), ID_W));
  assign w_rspOk      = bus.mem_ready && (w_rspIdx < N_REQ) && (r_outCnt[w_rspSlot] != '0);
  assign w_rspOneHot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_rspSlot;
  assign w_dec        = w_rspOk ? w_rspOneHot : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_r     <= 1'b0;
      bus.mem_w     <= 1'b0;
      bus.mem_id    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      r_rrPtr       <= '0;
    end else if (w_anyGrant) begin
      bus.mem_r     <= ~w_selRw;
      bus.mem_w     <= w_selRw;
      bus.mem_id    <= TAG_W'(pack_tag(int'(w_grantIdx), TAG_MAX_W'(w_selId), ID_W));
      bus.mem_addr  <= w_selAddr;
      bus.mem_wdata <= w_selData;
      r_rrPtr       <= w_grantIdx + IDX_W'(1);
    end else begin
      bus.mem_r     <= 1'b0;
      bus.mem_w     <= 1'b0;
    end
  end

  // Responses with an unknown owner or no outstanding work are dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_valid <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.tag_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= w_rspOk ? w_rspOneHot : '0;
      if (w_rspOk) begin
        bus.rsp_id   <= w_rspLocalId;
        bus.rsp_data <= bus.mem_rdata;
      end
      if (bus.mem_ready && !w_rspOk) bus.tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) r_outCnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_grant[i] && !w_dec[i] && r_outCnt[i] != CNT_MAX) begin
          r_outCnt[i] <= r_outCnt[i] + CNT_W'(1);
        end else if (!w_grant[i] && w_dec[i] && r_outCnt[i] != '0) begin
          r_outCnt[i] <= r_outCnt[i] - CNT_W'(1);
        end
      end
    end
  end

`ifdef DCARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.grant_cnt <= '0;
      bus.stall_cyc <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_grant[i]) bus.grant_cnt[i*16 +: 16] <= bus.grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (bus.mem_stall && (|bus.req_valid) && bus.stall_cyc != 16'hFFFF) begin
        bus.stall_cyc <= bus.stall_cyc + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed plus random bench for dcache_port_arbiter against a queue-based
// reference model of round-robin grants and per-requester credits.
module tb_dcache_port_arbiter;
  localparam int N_REQ   = 2;
  localparam int ID_W    = 4;
  localparam int MAX_OUT = 4;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = $clog2(N_REQ) + ID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  dcache_port_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .MAX_OUT(MAX_OUT), .DATA_W(DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                mPtr;
  int                mCnt [N_REQ];
  logic [ID_W-1:0]   mPend [N_REQ][$];
  int                lastGrant;
  logic              eMemR, eMemW, eTagErr;
  logic [TAG_W-1:0]  eMemId;
  logic [DATA_W-1:0] eMemAddr, eMemWdata, eRspData;
  logic [N_REQ-1:0]  eRspValid;
  logic [ID_W-1:0]   eRspId;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPtr = 0;
    for (int i = 0; i < N_REQ; i++) begin
      mCnt[i] = 0;
      mPend[i].delete();
    end
    eMemR = 0; eMemW = 0; eTagErr = 0;
    eMemId = '0; eMemAddr = '0; eMemWdata = '0;
    eRspValid = '0; eRspId = '0; eRspData = '0;
  endtask

  task automatic clearInputs();
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_id = '0;
    bus.mem_stall = 1'b0; bus.mem_ready = 1'b0;
    bus.mem_id_in = '0; bus.mem_rdata = '0;
  endtask

  task automatic setReq(input int i, input logic v, input logic rw,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [ID_W-1:0] id);
    bus.req_valid[i] = v;
    bus.req_rw[i]    = rw;
    bus.req_addr[i*DATA_W +: DATA_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
    bus.req_id[i*ID_W +: ID_W]       = id;
  endtask

  task automatic respondTo(input int i, input logic [DATA_W-1:0] d);
    int lid;
    lid = (mPend[i].size() > 0) ? int'(mPend[i][0]) : 0;
    bus.mem_ready = 1'b1;
    bus.mem_id_in = TAG_W'(i * (2 ** ID_W) + lid);
    bus.mem_rdata = d;
  endtask

  // One clock: check combinational stalls, predict, then check registered outputs.
  task automatic applyStimulus();
    int g, idx, j;
    logic [N_REQ-1:0] eStall;
    #1;
    g = -1;
    if (!bus.mem_stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        j = (mPtr + k) % N_REQ;
        if (g < 0 && bus.req_valid[j] && mCnt[j] < MAX_OUT) g = j;
      end
    end
    eStall = bus.req_valid;
    if (g >= 0) eStall[g] = 1'b0;
    checkOutput("req_stall", 64'(bus.req_stall), 64'(eStall));
    lastGrant = g;
    eRspValid = '0;
    if (bus.mem_ready) begin
      idx = int'(bus.mem_id_in) / (2 ** ID_W);
      if (idx < N_REQ && mCnt[idx] > 0) begin
        eRspValid[idx] = 1'b1;
        eRspId   = ID_W'(int'(bus.mem_id_in) % (2 ** ID_W));
        eRspData = bus.mem_rdata;
        mCnt[idx]--;
        if (mPend[idx].size() > 0) void'(mPend[idx].pop_front());
      end else begin
        eTagErr = 1'b1;
      end
    end
    if (g >= 0) begin
      eMemR     = !bus.req_rw[g];
      eMemW     = bus.req_rw[g];
      eMemId    = TAG_W'(g * (2 ** ID_W) + int'(bus.req_id[g*ID_W +: ID_W]));
      eMemAddr  = bus.req_addr[g*DATA_W +: DATA_W];
      eMemWdata = bus.req_data[g*DATA_W +: DATA_W];
      mCnt[g]++;
      mPend[g].push_back(bus.req_id[g*ID_W +: ID_W]);
      mPtr = (g + 1) % N_REQ;
    end else begin
      eMemR = 1'b0;
      eMemW = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("mem_r", 64'(bus.mem_r), 64'(eMemR));
    checkOutput("mem_w", 64'(bus.mem_w), 64'(eMemW));
    checkOutput("mem_id", 64'(bus.mem_id), 64'(eMemId));
    checkOutput("mem_addr", 64'(bus.mem_addr), 64'(eMemAddr));
    checkOutput("mem_wdata", 64'(bus.mem_wdata), 64'(eMemWdata));
    checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(eRspValid));
    checkOutput("rsp_id", 64'(bus.rsp_id), 64'(eRspId));
    checkOutput("rsp_data", 64'(bus.rsp_data), 64'(eRspData));
    checkOutput("tag_err", 64'(bus.tag_err), 64'(eTagErr));
  endtask

  task automatic drainAll();
    int who;
    clearInputs();
    for (int guard = 0; guard < 64; guard++) begin
      who = -1;
      for (int i = 0; i < N_REQ; i++) if (who < 0 && mCnt[i] > 0) who = i;
      if (who < 0) break;
      respondTo(who, DATA_W'($urandom));
      applyStimulus();
    end
    clearInputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ptrBefore;
    clearInputs();
    modelReset();
    #2 rst = 1'b0;
    bus.req_valid = 2'b11;
    #10;
    checkOutput("reset_req_stall", 64'(bus.req_stall), 64'h3);
    checkOutput("reset_mem_r", 64'(bus.mem_r), 64'h0);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    checkOutput("reset_tag_err", 64'(bus.tag_err), 64'h0);
    clearInputs();
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    $display("[TB] single read");
    setReq(0, 1'b1, 1'b0, 32'd40, 32'd0, 4'd3);
    applyStimulus();
    checkOutput("single_mem_r", 64'(bus.mem_r), 64'h1);
    checkOutput("single_mem_id", 64'(bus.mem_id), 64'h03);
    clearInputs();
    bus.mem_ready = 1'b1; bus.mem_id_in = 5'b00011; bus.mem_rdata = 32'd9000;
    applyStimulus();
    checkOutput("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    checkOutput("single_rsp_id", 64'(bus.rsp_id), 64'h3);
    checkOutput("single_rsp_data", 64'(bus.rsp_data), 64'd9000);
    clearInputs();

    $display("[TB] contention");
    for (int k = 0; k < 4; k++) begin
      setReq(0, 1'b1, 1'b0, 32'h100 + 32'(k), 32'd0, 4'(k));
      setReq(1, 1'b1, 1'b0, 32'h200 + 32'(k), 32'd0, 4'(k + 8));
      applyStimulus();
      checkOutput("contend_grant", 64'(bus.mem_id) >> ID_W, 64'((1 + k) % 2));
    end
    drainAll();

    $display("[TB] credit limit");
    for (int k = 0; k < 4; k++) begin
      setReq(1, 1'b1, 1'b1, 32'h300 + 32'(k), 32'hA0 + 32'(k), 4'(k));
      applyStimulus();
    end
    setReq(0, 1'b1, 1'b0, 32'h400, 32'd0, 4'd7);
    applyStimulus();
    checkOutput("credit_grant0", 64'(bus.mem_id) >> ID_W, 64'h0);
    setReq(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    respondTo(1, 32'd0);
    applyStimulus();
    bus.mem_ready = 1'b0;
    applyStimulus();
    checkOutput("credit_regrant_w", 64'(bus.mem_w), 64'h1);
    checkOutput("credit_regrant_idx", 64'(bus.mem_id) >> ID_W, 64'h1);
    drainAll();

    $display("[TB] mem_stall");
    ptrBefore = mPtr;
    bus.mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      setReq(0, 1'b1, 1'b0, 32'h500, 32'd0, 4'd1);
      setReq(1, 1'b1, 1'b1, 32'h600, 32'h66, 4'd2);
      applyStimulus();
      checkOutput("mstall_no_strobe", 64'(bus.mem_r | bus.mem_w), 64'h0);
    end
    bus.mem_stall = 1'b0;
    applyStimulus();
    checkOutput("mstall_first_grant", 64'(bus.mem_id) >> ID_W, 64'(ptrBefore));
    drainAll();

    $display("[TB] simultaneous grant and response");
    for (int k = 0; k < 2; k++) begin
      setReq(0, 1'b1, 1'b0, 32'h700 + 32'(k), 32'd0, 4'(k));
      applyStimulus();
    end
    respondTo(0, 32'h1234);
    applyStimulus();
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) applyStimulus();
    applyStimulus();
    checkOutput("simul_saturated", 64'(bus.mem_r | bus.mem_w), 64'h0);
    drainAll();

    $display("[TB] bad tag and mid-cycle reset");
    bus.mem_ready = 1'b1; bus.mem_id_in = 5'b10101;
    applyStimulus();
    checkOutput("badtag_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    checkOutput("badtag_err", 64'(bus.tag_err), 64'h1);
    clearInputs();
    applyStimulus();
    checkOutput("badtag_sticky", 64'(bus.tag_err), 64'h1);
    setReq(1, 1'b1, 1'b1, 32'h800, 32'h88, 4'd2);
    applyStimulus();
    setReq(0, 1'b1, 1'b0, 32'h900, 32'd0, 4'd1);
    #3 rst = 1'b0;
    #1;
    checkOutput("midrst_mem_w", 64'(bus.mem_w), 64'h0);
    checkOutput("midrst_mem_id", 64'(bus.mem_id), 64'h0);
    checkOutput("midrst_mem_addr", 64'(bus.mem_addr), 64'h0);
    checkOutput("midrst_tag_err", 64'(bus.tag_err), 64'h0);
    checkOutput("midrst_req_stall", 64'(bus.req_stall), 64'h3);
    modelReset();
    clearInputs();
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    bus.mem_ready = 1'b1; bus.mem_id_in = 5'b10010;
    applyStimulus();
    checkOutput("late_rsp_err", 64'(bus.tag_err), 64'h1);
    clearInputs();
    @(negedge clk) rst = 1'b0;
    modelReset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      int pick;
      for (int i = 0; i < N_REQ; i++) begin
        setReq(i, 1'($urandom), 1'($urandom), DATA_W'($urandom), DATA_W'($urandom),
               ID_W'($urandom_range(0, 15)));
      end
      bus.mem_stall = ($urandom_range(0, 3) == 0);
      bus.mem_ready = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, N_REQ - 1);
        if (mCnt[pick] == 0) pick = (pick + 1) % N_REQ;
        if (mCnt[pick] > 0) respondTo(pick, DATA_W'($urandom));
      end
      applyStimulus();
    end
    drainAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
